// File: rtl/gpio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_ctrl_pkg
//  Description : Shared sizes and FSM state encoding for the GPIO interrupt
//                scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_ctrl_pkg;

    localparam int NUM_SRC = 16;
    localparam int VEC_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLDOFF = 2'd2
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/gpio_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_rr_arbiter
//  Description : Combinational round-robin pick: first set request at or
//                after the pointer, wrapping from the top index back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_rr_arbiter
    import gpio_ctrl_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [VEC_W-1:0]   i_ptr,
    output logic [VEC_W-1:0]   o_grant,
    output logic               o_any
);

    logic [VEC_W-1:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest hit is left standing.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_idx = i_ptr + VEC_W'(k);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_any   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpio_intr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_intr_sched
//  Description : Collects GPIO edge events into pending/overflow flags and
//                presents them one at a time as a valid/ready vector stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_intr_sched
    import gpio_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         posedge_intr_status_set,
    input  logic [7:0]         negedge_intr_status_set,
    input  logic [NUM_SRC-1:0] src_enable,
    input  logic [7:0]         holdoff_cycles,
    input  logic [NUM_SRC-1:0] overflow_clr,
    output logic               intr_valid,
    output logic [VEC_W-1:0]   intr_vector,
    input  logic               intr_ready,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overflow,
    output logic               irq
);

    sched_state_e       r_state;
    sched_state_e       w_state_nxt;
    logic [VEC_W-1:0]   r_rr_ptr;
    logic [VEC_W-1:0]   r_vector;
    logic [7:0]         r_hold_cnt;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_overflow;
    logic               r_irq;

    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_ovf_evt;
    logic [VEC_W-1:0]   w_grant;
    logic               w_any;
    logic               w_load_vec;
    logic               w_handshake;

    assign w_set     = {negedge_intr_status_set, posedge_intr_status_set};
    assign w_clr     = w_handshake ? (NUM_SRC'(1) << r_vector) : '0;
    // A set landing on the bit being acknowledged re-arms it without overflow.
    assign w_ovf_evt = w_set & r_pending & ~w_clr;

    gpio_rr_arbiter u_arb (
        .i_req   (r_pending & src_enable),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_vec  = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_load_vec  = 1'b1;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (intr_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = (holdoff_cycles != 8'd0) ? ST_HOLDOFF : ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (r_hold_cnt <= 8'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_vector   <= '0;
            r_hold_cnt <= 8'd0;
        end else begin
            if (w_load_vec) begin
                r_vector <= w_grant;
            end
            if (w_handshake) begin
                r_rr_ptr   <= r_vector + VEC_W'(1);
                r_hold_cnt <= holdoff_cycles;
            end else if ((r_state == ST_HOLDOFF) && (r_hold_cnt != 8'd0)) begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_clr) | w_set;
            r_overflow <= (r_overflow & ~overflow_clr) | w_ovf_evt;
            r_irq      <= |(r_pending & src_enable);
        end
    end

    assign intr_valid  = (r_state == ST_PRESENT);
    assign intr_vector = r_vector;
    assign pending     = r_pending;
    assign overflow    = r_overflow;
    assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_intr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_intr_sched
//  Description : Self-checking bench for gpio_intr_sched; accepted vectors are
//                checked against a queue of expected source indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_intr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  posedge_intr_status_set = '0;
    logic [7:0]  negedge_intr_status_set = '0;
    logic [15:0] src_enable = '0;
    logic [7:0]  holdoff_cycles = '0;
    logic [15:0] overflow_clr = '0;
    logic        intr_valid;
    logic [3:0]  intr_vector;
    logic        intr_ready = 1'b0;
    logic [15:0] pending;
    logic [15:0] overflow;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_q[$];

    gpio_intr_sched dut (
        .clk                     (clk),
        .rst                     (rst),
        .posedge_intr_status_set (posedge_intr_status_set),
        .negedge_intr_status_set (negedge_intr_status_set),
        .src_enable              (src_enable),
        .holdoff_cycles          (holdoff_cycles),
        .overflow_clr            (overflow_clr),
        .intr_valid              (intr_valid),
        .intr_vector             (intr_vector),
        .intr_ready              (intr_ready),
        .pending                 (pending),
        .overflow                (overflow),
        .irq                     (irq)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so at negedge they show what the next edge samples.
    always @(negedge clk) begin
        logic [3:0] exp_v;
        if (!rst && intr_valid === 1'b1 && intr_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL hs_unexpected: accepted vector %0d, none expected", intr_vector);
            end else begin
                exp_v = exp_q.pop_front();
                if (intr_vector !== exp_v) begin
                    n_fail++;
                    $display("FAIL hs_vector: got %0d, expected %0d", intr_vector, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (intr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({intr_valid, intr_vector, pending, overflow, irq} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b vec=%h pend=%h ovf=%h irq=%b, all zero required",
                     intr_valid, intr_vector, pending, overflow, irq);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (intr_valid !== 1'b0 || pending !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b pend=%h, expected 0/0000", intr_valid, pending);
        end
    endtask

    task automatic test_latency();
        src_enable = 16'hFFFF;
        intr_ready = 1'b1;
        exp_q.push_back(4'd2);
        posedge_intr_status_set = 8'h04;
        tick();
        posedge_intr_status_set = 8'h00;
        n_checks++;
        if (intr_valid !== 1'b0 || pending !== 16'h0004) begin
            n_fail++;
            $display("FAIL lat_n1: valid=%b pend=%h, expected 0/0004", intr_valid, pending);
        end
        tick();
        n_checks++;
        if (intr_valid !== 1'b1 || intr_vector !== 4'h2 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_n2: valid=%b vec=%h irq=%b, expected 1/2/1", intr_valid, intr_vector, irq);
        end
        tick();
        n_checks++;
        if (intr_valid !== 1'b0 || pending !== 16'h0000) begin
            n_fail++;
            $display("FAIL lat_clear: valid=%b pend=%h, expected 0/0000", intr_valid, pending);
        end
        tick();
        tick();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_irq_drop: irq=%b, expected 0", irq);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        holdoff_cycles = 8'd0;
        intr_ready = 1'b1;
        src_enable = 16'hFFFF;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd15);
        posedge_intr_status_set = 8'h01;
        negedge_intr_status_set = 8'h80;
        tick();
        posedge_intr_status_set = 8'h00;
        negedge_intr_status_set = 8'h00;
        tick();
        n_checks++;
        if (intr_valid !== 1'b1 || intr_vector !== 4'd0) begin
            n_fail++;
            $display("FAIL rr_first: valid=%b vec=%0d, expected 1/0", intr_valid, intr_vector);
        end
        tick();
        n_checks++;
        if (intr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle_gap: valid=%b, expected 0", intr_valid);
        end
        tick();
        n_checks++;
        if (intr_valid !== 1'b1 || intr_vector !== 4'd15) begin
            n_fail++;
            $display("FAIL rr_second: valid=%b vec=%0d, expected 1/15", intr_valid, intr_vector);
        end
        tick();
        // Pointer is back at 0, so source 1 must beat source 15.
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd15);
        posedge_intr_status_set = 8'h02;
        negedge_intr_status_set = 8'h80;
        tick();
        posedge_intr_status_set = 8'h00;
        negedge_intr_status_set = 8'h00;
        tick();
        n_checks++;
        if (intr_valid !== 1'b1 || intr_vector !== 4'd1) begin
            n_fail++;
            $display("FAIL rr_wrap: valid=%b vec=%0d, expected 1/1", intr_valid, intr_vector);
        end
        repeat (4) tick();
    endtask

    task automatic test_holdoff();
        bit ok;
        int low;
        holdoff_cycles = 8'd3;
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd5);
        posedge_intr_status_set = 8'h30;
        tick();
        posedge_intr_status_set = 8'h00;
        wait_valid(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ho_first_timeout: valid=%b, expected 1 within 10 cycles", intr_valid);
        end
        tick();
        low = 0;
        while (intr_valid !== 1'b1 && low < 20) begin
            low++;
            tick();
        end
        n_checks++;
        if (low != 4) begin
            n_fail++;
            $display("FAIL ho_gap: %0d low cycles, expected 4", low);
        end
        repeat (8) tick();
        holdoff_cycles = 8'd0;
    endtask

    task automatic test_overflow();
        bit ok;
        src_enable = 16'h0000;
        intr_ready = 1'b1;
        negedge_intr_status_set = 8'h01;
        tick();
        negedge_intr_status_set = 8'h00;
        tick();
        negedge_intr_status_set = 8'h01;
        tick();
        negedge_intr_status_set = 8'h00;
        n_checks++;
        if (pending !== 16'h0100 || overflow !== 16'h0100) begin
            n_fail++;
            $display("FAIL ovf_set: pend=%h ovf=%h, expected 0100/0100", pending, overflow);
        end
        overflow_clr = 16'h0100;
        tick();
        overflow_clr = 16'h0000;
        n_checks++;
        if (overflow !== 16'h0000 || pending !== 16'h0100) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%h pend=%h, expected 0000/0100", overflow, pending);
        end
        negedge_intr_status_set = 8'h01;
        overflow_clr = 16'h0100;
        tick();
        negedge_intr_status_set = 8'h00;
        overflow_clr = 16'h0000;
        n_checks++;
        if (overflow !== 16'h0100) begin
            n_fail++;
            $display("FAIL ovf_clr_vs_event: ovf=%h, expected 0100", overflow);
        end
        overflow_clr = 16'h0100;
        tick();
        overflow_clr = 16'h0000;
        exp_q.push_back(4'd8);
        src_enable = 16'h0100;
        wait_valid(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovf_drain_timeout: valid=%b, expected 1 within 10 cycles", intr_valid);
        end
        tick();
        tick();
        n_checks++;
        if (pending !== 16'h0000 || overflow !== 16'h0000) begin
            n_fail++;
            $display("FAIL ovf_drained: pend=%h ovf=%h, expected 0000/0000", pending, overflow);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        intr_ready = 1'b0;
        src_enable = 16'hFFFF;
        exp_q.push_back(4'd6);
        posedge_intr_status_set = 8'h40;
        tick();
        posedge_intr_status_set = 8'h00;
        wait_valid(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_timeout: valid=%b, expected 1 within 10 cycles", intr_valid);
        end
        src_enable = 16'h0000;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (intr_valid !== 1'b1 || intr_vector !== 4'd6) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d cycles lost valid/vector 6, expected 0", bad);
        end
        // Accept and re-raise the same source in one cycle.
        intr_ready = 1'b1;
        posedge_intr_status_set = 8'h40;
        tick();
        posedge_intr_status_set = 8'h00;
        n_checks++;
        if (intr_valid !== 1'b0 || pending !== 16'h0040 || overflow !== 16'h0000) begin
            n_fail++;
            $display("FAIL stall_set_clear: valid=%b pend=%h ovf=%h, expected 0/0040/0000",
                     intr_valid, pending, overflow);
        end
        exp_q.push_back(4'd6);
        src_enable = 16'hFFFF;
        wait_valid(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_repost_timeout: valid=%b, expected 1 within 10 cycles", intr_valid);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_present();
        bit ok;
        int seen;
        intr_ready = 1'b0;
        src_enable = 16'hFFFF;
        posedge_intr_status_set = 8'h08;
        negedge_intr_status_set = 8'h02;
        tick();
        posedge_intr_status_set = 8'h00;
        negedge_intr_status_set = 8'h00;
        tick();
        posedge_intr_status_set = 8'h08;
        tick();
        posedge_intr_status_set = 8'h00;
        wait_valid(10, ok);
        n_checks++;
        if (!ok || overflow !== 16'h0008) begin
            n_fail++;
            $display("FAIL rstp_setup: valid=%b ovf=%h, expected 1/0008", intr_valid, overflow);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (intr_valid !== 1'b0 || pending !== 16'h0 || overflow !== 16'h0 || intr_vector !== 4'h0) begin
            n_fail++;
            $display("FAIL rstp_async: valid=%b pend=%h ovf=%h vec=%h, expected all 0",
                     intr_valid, pending, overflow, intr_vector);
        end
        tick();
        rst = 1'b0;
        intr_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (intr_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rstp_no_vector: valid seen %0d cycles, expected 0", seen);
        end
        exp_q.push_back(4'd1);
        posedge_intr_status_set = 8'h02;
        tick();
        posedge_intr_status_set = 8'h00;
        wait_valid(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstp_new_event_timeout: valid=%b, expected 1 within 10 cycles", intr_valid);
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_round_robin();
        test_holdoff();
        test_overflow();
        test_stall();
        test_reset_present();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d vectors never accepted, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_intr_sched.md
GPIO_INTR_SCHED -- requirements
Module: gpio_intr_sched

Interface
REQ-001 SHALL expose clk  input  1  single clock; all flops rising-edge.
REQ-002 SHALL expose rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose posedge_intr_status_set  input  8  per-32-bit-group posedge event pulses; source index j = group.
REQ-004 SHALL expose negedge_intr_status_set  input  8  per-group negedge event pulses; source index j = 8 + group.
REQ-005 SHALL expose src_enable  input  16  1 = source eligible for presentation.
REQ-006 SHALL expose holdoff_cycles  input  8  idle cycles forced after each acknowledge; 0 = none.
REQ-007 SHALL expose overflow_clr  input  16  write-1-to-clear strobe for overflow bits.
REQ-008 SHALL expose intr_valid  output  1  vector presented.
REQ-009 SHALL expose intr_vector  output  4  {edge (1 = neg), group[2:0]} = source index j.
REQ-010 SHALL expose intr_ready  input  1  consumer accepts vector.
REQ-011 SHALL expose pending  output  16  registered pending flags.
REQ-012 SHALL expose overflow  output  16  sticky: event arrived while already pending.
REQ-013 SHALL expose irq  output  1  registered |(pending & src_enable).

Function
REQ-014 pending[j] SHALL set the cycle after its set pulse, regardless of src_enable.
REQ-015 Set pulse on j with pending[j] already 1 and not being cleared SHALL set overflow[j]; pending stays 1.
REQ-016 Set and handshake-clear of the same j in one cycle SHALL leave pending[j]=1, no overflow.
REQ-017 overflow_clr[j] SHALL clear overflow[j] next cycle; a simultaneous overflow event wins (bit stays 1).
REQ-018 FSM states SHALL be IDLE, PRESENT, HOLDOFF.
REQ-019 IDLE: if (pending & src_enable) != 0, SHALL pick the first eligible index at or after rr_ptr (wrapping 15->0), register it into intr_vector, go PRESENT; else stay.
REQ-020 PRESENT: intr_valid SHALL be 1 and intr_vector stable until intr_valid & intr_ready; never withdrawn, even if src_enable[j] drops.
REQ-021 On handshake: pending[sel] cleared, rr_ptr = (sel+1) mod 16, intr_valid low next cycle; go HOLDOFF if holdoff_cycles != 0, else IDLE.
REQ-022 HOLDOFF SHALL last exactly holdoff_cycles cycles (counter sampled at handshake), then IDLE.
REQ-023 Latency: set pulse in cycle N with FSM idle and source enabled SHALL give intr_valid=1 in cycle N+2.
REQ-024 Back-to-back with holdoff 0: next intr_valid SHALL rise 2 cycles after handshake (one IDLE cycle).
REQ-025 intr_ready while intr_valid=0 SHALL be ignored.

Reset
REQ-026 rst SHALL asynchronously force: state IDLE, rr_ptr 0, holdoff counter 0, pending 0, overflow 0, intr_valid 0, intr_vector 0, irq 0.
REQ-027 rst mid-PRESENT SHALL drop intr_valid immediately and discard the selected event.

Structure
REQ-028 Package gpio_ctrl_pkg SHALL hold NUM_SRC=16, VEC_W=4, and the FSM state enum.
REQ-029 Round-robin pick SHALL be a combinational sub-module gpio_rr_arbiter (inputs: 16-bit request, 4-bit pointer; outputs: grant index, any-grant).

Verification
REQ-030 Reset, then posedge_intr_status_set=8'h04 for one cycle, src_enable=16'hFFFF, intr_ready=1 -> intr_valid at N+2 with vector 4'h2; pending[2] clear after handshake.
REQ-031 pending=16'h8001 enabled, rr_ptr 0, ready=1, holdoff 0 -> vectors 0 then 15, then rr_ptr wraps to 0.
REQ-032 holdoff_cycles=3, two pending sources -> exactly 3 cycles with intr_valid=0 between handshakes, plus one IDLE cycle.
REQ-033 negedge_intr_status_set=8'h01 twice without acknowledge -> pending[8]=1, overflow[8]=1; overflow_clr=16'h0100 -> overflow[8]=0.
REQ-034 intr_ready=0 for 10 cycles while src_enable[sel] deasserted -> intr_valid and intr_vector held; then ready=1 completes handshake.
REQ-035 rst asserted during PRESENT -> intr_valid, pending, overflow all 0 immediately; no vector after release until new event.
